ysyx_25030093_ifu: RTL
======================

Name: ysyx_25030093_ifu

Overview:
Instruction fetch unit between the PC register and the decode stage. Takes the current PC, issues one AXI4-Lite read per instruction, and captures the returned word. Presents the word to decode with a valid/ready handshake. Pulses `pc_advance`, wired to the PC register's `in_valid`, when decode accepts an instruction. Single outstanding request, no prefetch.

Parameters:
- ADDR_W, 32, address width of pc and araddr.
- DATA_W, 32, instruction/rdata width; only 32 supported.
- TIMEOUT, 255, cycles waiting in ADDR or DATA before a bus-timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC from the PC register.
- araddr  out  ADDR_W  AXI read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  DATA_W  read data.
- rresp  in  2  read response; nonzero = error.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- inst  out  32  fetched instruction to decode.
- inst_pc  out  ADDR_W  PC the instruction was fetched from.
- inst_fault  out  1  fetch error (rresp!=0 or timeout); inst forced to 0x00000013.
- out_valid  out  1  inst/inst_pc/inst_fault valid.
- out_ready  in  1  decode ready.
- pc_advance  out  1  one-cycle pulse on the accept edge (out_valid & out_ready).
- flush  in  1  discard current fetch/hold; refetch from pc.
- perf_fetch  out  32  completed fetch count (IFU_PERF_EN).
- perf_stall  out  32  cycles in ADDR+DATA (IFU_PERF_EN).

Behaviour:
- Reset (rst=0, async) values: state=IDLE; arvalid=0, rready=0, out_valid=0, pc_advance=0; inst=0, inst_pc=0, inst_fault=0; timeout counter=0; perf counters=0.
- FSM states: IDLE, ADDR, DATA, HOLD, WAIT.
- IDLE: next cycle -> ADDR. Gives one cycle after reset release.
- ADDR: arvalid=1, araddr=pc (pc sampled into a request register on entry; araddr stays stable while arvalid=1). On arready -> DATA.
- DATA: rready=1. On rvalid, capture rdata, the request PC and (rresp!=0) -> HOLD.
- HOLD: out_valid=1, outputs stable. On out_ready: pc_advance=1 for that cycle -> WAIT.
- WAIT: out_valid=0, one cycle for the PC register to update -> ADDR with the new pc.
- Latency: minimum 3 cycles from ADDR entry to out_valid (ADDR 1, DATA 1, HOLD registered). Best-case throughput is one instruction per 4 cycles.
- Fault: rresp!=0 or timeout -> inst=0x00000013 (nop), inst_fault=1, handled like a normal HOLD.
- Timeout: counter resets on entry to ADDR. It counts each cycle in ADDR/DATA. Reaching TIMEOUT in DATA -> HOLD with fault. Reaching TIMEOUT in ADDR holds arvalid; there is no AXI abort. Fault is raised only after the request completes.
- Flush in IDLE/WAIT/HOLD: drop out_valid, no pc_advance -> ADDR next cycle.
- Flush in ADDR: request is not withdrawn. A sticky drop flag is set, the response is consumed and discarded, then -> ADDR (refetch).
- Flush in DATA: same as ADDR; the response is discarded.
- Flush and out_ready in the same HOLD cycle: flush wins, no pc_advance.
- rvalid seen outside DATA is ignored (rready=0).
- Reset mid-transaction clears all state immediately. The AXI slave is assumed to be reset by the same rst.

Optional Feature:
- Macro: IFU_PERF_EN.
- With the macro: perf_fetch increments on each accepted HOLD. perf_stall increments each cycle in ADDR or DATA. Both counters wrap at 2^32.
- Without the macro: both ports tie to 0 and no counter flops are generated.

Decomposition:
- Shared package holds:
  - the IFU state enum (IDLE/ADDR/DATA/HOLD/WAIT);
  - the NOP_INST constant 0x00000013;
  - the AXI_RESP_OKAY constant 2'b00;
  - the RESET_PC constant 0x80000000, shared with the PC register.
- One sub-module is natural: ysyx_25030093_ifu_timeout, a loadable down-counter with an expire flag.

Test Plan:
- Reset then pc=0x80000000, arready=1 immediately, rvalid 1 cycle later with rdata=0x00500093, out_ready=1 -> inst=0x00500093, inst_pc=0x80000000, single pc_advance pulse, next araddr=0x80000004.
- arready delayed 5 cycles, rvalid delayed 7 -> araddr stable throughout; out_valid only after rvalid; perf_stall grows by the cycles spent in ADDR+DATA.
- out_ready held 0 for 10 cycles in HOLD -> inst, out_valid stable; no new arvalid; pc_advance=0.
- rresp=2'b10 -> inst=0x00000013, inst_fault=1, out_valid=1.
- flush asserted in DATA, then rvalid with rdata=0xDEADBEEF -> data discarded, new arvalid with the current pc, no pc_advance.
- TIMEOUT=4, rvalid never arrives -> HOLD with inst_fault=1 after 4 DATA cycles. Async rst=0 mid-DATA -> arvalid, rready, out_valid drop to 0 immediately.

Source files
------------

// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings and architectural constants.
// Also used by the PC register (RESET_PC).
package ysyx_25030093_ifu_pkg;

  typedef logic [2:0] ifu_state_t;

  localparam ifu_state_t StIdle = 3'd0;
  localparam ifu_state_t StAddr = 3'd1;
  localparam ifu_state_t StData = 3'd2;
  localparam ifu_state_t StHold = 3'd3;
  localparam ifu_state_t StWait = 3'd4;

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC      = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu_if.sv
// AXI4-Lite read channel between the IFU (master) and instruction memory (slave).
interface ysyx_25030093_ifu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ysyx_25030093_ifu_timeout.sv
// Loadable down-counter for the IFU bus timeout; expired is high once the
// count reaches zero. TIMEOUT=0 disables expiry entirely.
module ysyx_25030093_ifu_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(TIMEOUT);
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == '0);

endmodule

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, valid/ready to decode.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ysyx_25030093_ifu
  import ysyx_25030093_ifu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  ysyx_25030093_ifu_if.master axi,
  output logic [31:0]         inst,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic                inst_fault,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                pc_advance,
  input  logic                flush,
  output logic [31:0]         perf_fetch,
  output logic [31:0]         perf_stall
);

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] req_q;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              fault_q;
  logic [DATA_W-1:0] rdata;
  logic              tmo_expired;
  logic              in_addr, in_data, resp_done, enter_addr, capture;

  assign rdata     = axi.rdata;
  assign in_addr   = (state_q == StAddr);
  assign in_data   = (state_q == StData);
  // A timed-out DATA cycle completes the request just like a response.
  assign resp_done = in_data && (axi.rvalid || tmo_expired);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: state_d = StAddr;
      StAddr: begin
        if (flush) drop_d = 1'b1;
        if (axi.arready) state_d = StData;
      end
      StData: begin
        if (resp_done) begin
          state_d = (drop_q || flush) ? StAddr : StHold;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (flush) state_d = StAddr;
        else if (out_ready) state_d = StWait;
      end
      StWait:  state_d = StAddr;
      default: state_d = StIdle;
    endcase
  end

  assign enter_addr = (state_d == StAddr) && !in_addr;
  assign capture    = resp_done && !drop_q && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (enter_addr) req_q <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else if (capture) begin
      inst_pc_q <= req_q;
      if (axi.rvalid && (axi.rresp == AXI_RESP_OKAY)) begin
        inst_q  <= rdata[31:0];
        fault_q <= 1'b0;
      end else begin
        inst_q  <= NOP_INST;
        fault_q <= 1'b1;
      end
    end
  end

  ysyx_25030093_ifu_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (enter_addr),
    .count   (in_addr || in_data),
    .expired (tmo_expired)
  );

  assign axi.araddr  = req_q;
  assign axi.arvalid = in_addr;
  assign axi.rready  = in_data;

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;
  assign out_valid  = (state_q == StHold);
  // Flush wins over a same-cycle accept.
  assign pc_advance = out_valid && out_ready && !flush;

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pc_advance) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (in_addr || in_data) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule
